// File: rtl/scroll_digit_driver_pkg.sv
// Shared constants, types and helpers for the scroll display digit driver.
// Used by scroll_digit_driver and tick_divider.
package scroll_digit_driver_pkg;

  localparam int DEF_NUM_DIGITS  = 4;
  localparam int DEF_MSG_LEN     = 16;
  localparam int DEF_REFRESH_DIV = 100000;
  localparam int DEF_SCROLL_DIV  = 50000000;

  // Widest anode bank supported; callers slice down to their own digit count.
  localparam logic [7:0] ANODES_OFF = 8'hFF;

  typedef enum logic {
    DIR_INC = 1'b0,
    DIR_DEC = 1'b1
  } scroll_dir_e;

  function automatic int cnt_width(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/scroll_digit_driver_tick_divider.sv
// Free-running modulo-DIV counter with an enable; tick is high on the
// terminal count of an enabled cycle, and the count holds while en=0.
module tick_divider
  import scroll_digit_driver_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int W = cnt_width(DIV);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = en && (cnt_q == W'(DIV - 1));
    cnt_d = cnt_q;
    if (en) cnt_d = tick ? '0 : cnt_q + W'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/scroll_digit_driver.sv
// Scrolling multiplexed digit driver: message buffer, anode scan and window offset.
// Optional SCROLL_DIR_EN adds a scroll_dir input allowing pos to decrement.
module scroll_digit_driver
  import scroll_digit_driver_pkg::*;
#(
  parameter int NUM_DIGITS  = DEF_NUM_DIGITS,
  parameter int MSG_LEN     = DEF_MSG_LEN,
  parameter int REFRESH_DIV = DEF_REFRESH_DIV,
  parameter int SCROLL_DIV  = DEF_SCROLL_DIV
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [3:0]            wr_addr,
  input  logic [3:0]            wr_data,
`ifdef SCROLL_DIR_EN
  input  logic                  scroll_dir,
`endif
  input  logic                  scroll_en,
  output logic [3:0]            hex_out,
  output logic [NUM_DIGITS-1:0] an,
  output logic [3:0]            pos
);

  localparam int DW = cnt_width(NUM_DIGITS);
  localparam int AW = cnt_width(MSG_LEN);

  logic rfr_tick, scr_tick;

  tick_divider #(.DIV(REFRESH_DIV)) u_refresh (
    .clk (clk), .rst (rst), .en (1'b1), .tick (rfr_tick)
  );

  tick_divider #(.DIV(SCROLL_DIV)) u_scroll (
    .clk (clk), .rst (rst), .en (scroll_en), .tick (scr_tick)
  );

  logic [3:0]            msg_q [MSG_LEN];
  logic [DW-1:0]         d_q, d_d, d_next;
  logic                  lit_q, lit_d;
  logic [3:0]            pos_q, pos_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [3:0]            hex_q, hex_d;
  logic [5:0]            fetch_sum;
  logic [5:0]            fetch_idx;
  logic                  wr_ok;
  scroll_dir_e           dir;

  always_comb begin
`ifdef SCROLL_DIR_EN
    dir = scroll_dir_e'(scroll_dir);
`else
    dir = DIR_INC;
`endif
  end

  assign wr_ok = wr_en && ({1'b0, wr_addr} < 5'(MSG_LEN));

  always_comb begin
    d_d   = d_q;
    lit_d = lit_q;
    pos_d = pos_q;
    an_d  = an_q;
    hex_d = hex_q;

    // Until the first refresh tick nothing is lit, so that tick lands on digit 0.
    if (!lit_q)                            d_next = '0;
    else if (d_q == DW'(NUM_DIGITS - 1))   d_next = '0;
    else                                   d_next = d_q + DW'(1);

    // Leftmost digit (index NUM_DIGITS-1) shows msg[pos]; wrap modulo MSG_LEN.
    fetch_sum = 6'(pos_q) + 6'(NUM_DIGITS - 1) - 6'(d_next);
    fetch_idx = (fetch_sum >= 6'(MSG_LEN)) ? fetch_sum - 6'(MSG_LEN) : fetch_sum;

    if (rfr_tick) begin
      d_d   = d_next;
      lit_d = 1'b1;
      an_d  = ~(NUM_DIGITS'(1) << d_next);
      hex_d = msg_q[AW'(fetch_idx)];
    end

    if (scr_tick) begin
      if (dir == DIR_DEC) pos_d = (pos_q == 4'd0) ? 4'(MSG_LEN - 1) : pos_q - 4'd1;
      else                pos_d = (pos_q == 4'(MSG_LEN - 1)) ? 4'd0 : pos_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q   <= '0;
      lit_q <= 1'b0;
      pos_q <= '0;
      an_q  <= ANODES_OFF[NUM_DIGITS-1:0];
      hex_q <= 4'h0;
    end else begin
      d_q   <= d_d;
      lit_q <= lit_d;
      pos_q <= pos_d;
      an_q  <= an_d;
      hex_q <= hex_d;
    end
  end

  // NOTE: the message buffer is reset because a cleared display after reset is visible behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MSG_LEN; i++) msg_q[i] <= 4'h0;
    end else if (wr_ok) begin
      msg_q[AW'(wr_addr)] <= wr_data;
    end
  end

  assign hex_out = hex_q;
  assign an      = an_q;
  assign pos     = pos_q;

endmodule

// File: tb/tb_scroll_digit_driver.sv
// Self-checking bench for scroll_digit_driver (4 digits, 8-nibble message).
// Define SCROLL_DIR_EN for both bench and RTL to exercise reverse scrolling.
module tb_scroll_digit_driver;

  localparam int ND = 4;
  localparam int ML = 8;
  localparam int RD = 4;
  localparam int SD = 40;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [3:0]    wr_addr;
  logic [3:0]    wr_data;
  logic          scroll_en;
  logic          scroll_dir;
  logic [3:0]    hex_out;
  logic [ND-1:0] an;
  logic [3:0]    pos;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  scroll_digit_driver #(
    .NUM_DIGITS (ND), .MSG_LEN (ML), .REFRESH_DIV (RD), .SCROLL_DIV (SD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
`ifdef SCROLL_DIR_EN
    .scroll_dir(scroll_dir),
`endif
    .scroll_en (scroll_en),
    .hex_out   (hex_out),
    .an        (an),
    .pos       (pos)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: cycle counts, a message array and the lit digit as plain integers.
  int         m_msg [ML];
  int         m_pos, m_rcnt, m_scnt, m_digit;
  logic [3:0] m_an, m_hex;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ML; i++) m_msg[i] = 0;
      m_pos = 0; m_rcnt = 0; m_scnt = 0; m_digit = -1;
      m_an = 4'hF; m_hex = 4'h0;
    end else begin
      bit step;
      if (m_rcnt == RD - 1) begin
        m_rcnt  = 0;
        m_digit = (m_digit < 0) ? 0 : (m_digit + 1) % ND;
        m_an    = 4'hF ^ (4'h1 << m_digit);
        m_hex   = 4'(m_msg[(m_pos + ND - 1 - m_digit) % ML]);
      end else begin
        m_rcnt++;
      end
      step = 1'b0;
      if (scroll_en) begin
        if (m_scnt == SD - 1) begin
          m_scnt = 0;
          step   = 1'b1;
        end else begin
          m_scnt++;
        end
      end
      if (wr_en && wr_addr < ML) m_msg[wr_addr] = int'(wr_data);
      if (step) begin
`ifdef SCROLL_DIR_EN
        if (scroll_dir) m_pos = (m_pos + ML - 1) % ML;
        else            m_pos = (m_pos + 1) % ML;
`else
        m_pos = (m_pos + 1) % ML;
`endif
      end
    end
  end

  always @(negedge clk) begin
    check("model_an", 32'(an), 32'(m_an));
    check("model_hex", 32'(hex_out), 32'(m_hex));
    check("model_pos", 32'(pos), 32'(m_pos));
  end

  // Waits for the slot boundary where an becomes pat, then checks an and hex_out.
  task automatic wait_an(input string name, input logic [3:0] pat, input logic [3:0] exp_hex);
    for (int i = 0; i < 40 && an == pat; i++) @(negedge clk);
    for (int i = 0; i < 40 && an != pat; i++) @(negedge clk);
    check({name, "_an"}, 32'(an), 32'(pat));
    check({name, "_hex"}, 32'(hex_out), 32'(exp_hex));
  endtask

  task automatic run_scroll(input int cycles);
    scroll_en = 1'b1;
    repeat (cycles) @(negedge clk);
    scroll_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    scroll_en = 1'b0; scroll_dir = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_an", 32'(an), 32'hF);
    check("reset_hex", 32'(hex_out), 32'h0);
    check("reset_pos", 32'(pos), 32'h0);

    // Scan order after reset release
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("dark_before_first_tick", 32'(an), 32'hF);
    @(negedge clk);
    check("first_lit", 32'(an), 32'b1110);
    repeat (4) @(negedge clk); check("scan_1", 32'(an), 32'b1101);
    repeat (4) @(negedge clk); check("scan_2", 32'(an), 32'b1011);
    repeat (4) @(negedge clk); check("scan_3", 32'(an), 32'b0111);
    repeat (4) @(negedge clk); check("scan_4", 32'(an), 32'b1110);

    // Load 1..8 with scrolling frozen
    for (int i = 0; i < ML; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = 4'(i + 1);
      @(negedge clk);
    end
    wr_en = 1'b0;
    repeat (16) @(negedge clk);
    wait_an("p0_left", 4'b0111, 4'h1);
    wait_an("p0_d2", 4'b1011, 4'h2);
    wait_an("p0_d1", 4'b1101, 4'h3);
    wait_an("p0_right", 4'b1110, 4'h4);
    check("p0_pos", 32'(pos), 32'h0);

    // Seven scroll steps, then wrap to 0
    run_scroll(280);
    check("pos_7", 32'(pos), 32'h7);
    repeat (16) @(negedge clk);
    wait_an("p7_left", 4'b0111, 4'h8);
    wait_an("p7_d2", 4'b1011, 4'h1);
    wait_an("p7_d1", 4'b1101, 4'h2);
    wait_an("p7_right", 4'b1110, 4'h3);
    run_scroll(40);
    check("pos_wrap", 32'(pos), 32'h0);

    // Write collides with the fetch of msg[5] at pos 2 (rightmost digit)
    run_scroll(80);
    check("pos_2", 32'(pos), 32'h2);
    repeat (16) @(negedge clk);
    wait_an("p2_left", 4'b0111, 4'h3);
    repeat (3) @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 4'hA;
    @(negedge clk);
    wr_en = 1'b0;
    check("collide_an", 32'(an), 32'b1110);
    check("collide_old", 32'(hex_out), 32'h6);
    repeat (16) @(negedge clk);
    check("revisit_an", 32'(an), 32'b1110);
    check("revisit_new", 32'(hex_out), 32'hA);
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 4'hF;
    @(negedge clk);
    wr_en = 1'b0;

    // Pause the scroll counter at count 20
    run_scroll(20);
    repeat (100) @(negedge clk);
    check("frozen_pos", 32'(pos), 32'h2);
    scroll_en = 1'b1;
    repeat (19) @(negedge clk);
    check("resume_19", 32'(pos), 32'h2);
    @(negedge clk);
    check("resume_20", 32'(pos), 32'h3);
    repeat (120) @(negedge clk);
    scroll_en = 1'b0;
    check("pos_6", 32'(pos), 32'h6);
    repeat (16) @(negedge clk);
    wait_an("p6_left", 4'b0111, 4'h7);
    wait_an("addr9_ignored", 4'b1110, 4'h2);

    // Asynchronous reset mid-scan
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_an", 32'(an), 32'hF);
    check("async_hex", 32'(hex_out), 32'h0);
    check("async_pos", 32'(pos), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rerun_dark", 32'(an), 32'hF);
    @(negedge clk);
    check("rerun_first", 32'(an), 32'b1110);
    check("rerun_hex", 32'(hex_out), 32'h0);

`ifdef SCROLL_DIR_EN
    scroll_dir = 1'b1;
    run_scroll(40);
    check("rev_pos_7", 32'(pos), 32'h7);
    run_scroll(40);
    check("rev_pos_6", 32'(pos), 32'h6);
    scroll_dir = 1'b0;
`endif

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
